// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg -- shared constants and types for the RV32I pipeline stages.
//   ALU_*   : ALUControl encodings consumed by the execute stage ALU
//   FWD_*   : hazard-unit forward-select encodings for operands A and B
//   m_ctrl_t: control bundle carried from the E stage into the M stage
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic result_src;
    } m_ctrl_t;

endpackage

// File: rtl/exec_alu.sv
// ---------------------------------------------------------------------------
// exec_alu -- purely combinational execute-stage ALU.
//   SrcA, SrcB  : operands (XLEN)
//   ALUControl  : operation select (see pipe_pkg ALU_*)
//   Result      : operation result, wraps modulo 2^XLEN
//   Zero        : Result == 0, used for beq resolution
// Unlisted ALUControl codes produce 0.
// ---------------------------------------------------------------------------
module exec_alu
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = SrcA + SrcB;
            ALU_SUB: Result = SrcA - SrcB;
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_SLT: Result = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// ---------------------------------------------------------------------------
// execute_cycle -- execute stage of the 5-stage RV32I pipeline.
//   Inputs : D->E register outputs (controls, RD1_E/RD2_E, Imm_Ext_E, RD_E,
//            PCE, PCPlus4E), hazard-unit ForwardAE/ForwardBE and the
//            forward paths ALUResultM_fw (M stage) and ResultW (W stage).
//   Outputs: PCSrcE/PCTargetE (combinational, back to fetch) and the E->M
//            register: RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM,
//            WriteDataM, PCPlus4M.
//   clk, rst: rst is asynchronous active-low and clears every M output.
// Optional build macro EXEC_PERF_CNT_EN adds exec_cnt (issued instructions
// that write, store or branch) and taken_cnt (taken branches).
// ---------------------------------------------------------------------------
module execute_cycle
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteE,
    input  logic              ALUSrcE,
    input  logic              MemWriteE,
    input  logic              ResultSrcE,
    input  logic              BranchE,
    input  logic [2:0]        ALUControlE,
    input  logic [XLEN-1:0]   RD1_E,
    input  logic [XLEN-1:0]   RD2_E,
    input  logic [XLEN-1:0]   Imm_Ext_E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [XLEN-1:0]   PCE,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [XLEN-1:0]   ALUResultM_fw,
    input  logic [XLEN-1:0]   ResultW,
    output logic              PCSrcE,
    output logic [XLEN-1:0]   PCTargetE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              ResultSrcM,
    output logic [REG_AW-1:0] RD_M,
    output logic [XLEN-1:0]   ALUResultM,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [XLEN-1:0]   PCPlus4M
`ifdef EXEC_PERF_CNT_EN
    ,
    output logic [31:0]       exec_cnt,
    output logic [31:0]       taken_cnt
`endif
);

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result;
    logic            zero;
    m_ctrl_t         ctrl_m;

    // Reserved select 2'b11 falls through to the register-file value.
    always_comb begin
        src_a = RD1_E;
        case (ForwardAE)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALUResultM_fw;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        fwd_b = RD2_E;
        case (ForwardBE)
            FWD_WB:  fwd_b = ResultW;
            FWD_MEM: fwd_b = ALUResultM_fw;
            default: fwd_b = RD2_E;
        endcase
    end

    // Store data is the forwarded rs2, taken before the immediate mux.
    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

    exec_alu #(.XLEN(XLEN)) u_alu (
        .SrcA       (src_a),
        .SrcB       (src_b),
        .ALUControl (ALUControlE),
        .Result     (alu_result),
        .Zero       (zero)
    );

    assign PCSrcE    = BranchE & zero;
    assign PCTargetE = PCE + Imm_Ext_E;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_m     <= '0;
            RD_M       <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            ctrl_m     <= '{reg_write: RegWriteE, mem_write: MemWriteE, result_src: ResultSrcE};
            RD_M       <= RD_E;
            ALUResultM <= alu_result;
            WriteDataM <= fwd_b;
            PCPlus4M   <= PCPlus4E;
        end
    end

    assign RegWriteM  = ctrl_m.reg_write;
    assign MemWriteM  = ctrl_m.mem_write;
    assign ResultSrcM = ctrl_m.result_src;

`ifdef EXEC_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exec_cnt  <= '0;
            taken_cnt <= '0;
        end else begin
            if (RegWriteE | MemWriteE | BranchE) exec_cnt <= exec_cnt + 32'd1;
            if (PCSrcE)                          taken_cnt <= taken_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_execute_cycle.sv
// ---------------------------------------------------------------------------
// tb_execute_cycle -- self-checking bench for execute_cycle.
// A behavioural reference (plain arithmetic on the current inputs) predicts
// the combinational branch outputs and the next M-stage contents; a compare
// process checks every negedge, and directed cases pin literal values.
// ---------------------------------------------------------------------------
module tb_execute_cycle;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]        ALUControlE;
    logic [XLEN-1:0]   RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [REG_AW-1:0] RD_E;
    logic [1:0]        ForwardAE, ForwardBE;
    logic [XLEN-1:0]   ALUResultM_fw, ResultW;
    logic              PCSrcE;
    logic [XLEN-1:0]   PCTargetE;
    logic              RegWriteM, MemWriteM, ResultSrcM;
    logic [REG_AW-1:0] RD_M;
    logic [XLEN-1:0]   ALUResultM, WriteDataM, PCPlus4M;
`ifdef EXEC_PERF_CNT_EN
    logic [31:0]       exec_cnt, taken_cnt;
`endif

    always #5 clk = ~clk;

    execute_cycle #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUResultM_fw(ALUResultM_fw), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M)
`ifdef EXEC_PERF_CNT_EN
        , .exec_cnt(exec_cnt), .taken_cnt(taken_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] rf);
        if (s == 2'd1) return ResultW;
        if (s == 2'd2) return ALUResultM_fw;
        return rf;
    endfunction

    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_wd();
        return fwd(ForwardBE, RD2_E);
    endfunction

    function automatic logic [31:0] m_res();
        return alu(ALUControlE, fwd(ForwardAE, RD1_E), ALUSrcE ? Imm_Ext_E : m_wd());
    endfunction

    function automatic logic m_taken();
        return BranchE && (m_res() == 32'd0);
    endfunction

    logic        e_rw, e_mw, e_rs;
    logic [4:0]  e_rd;
    logic [31:0] e_res, e_wd, e_pc4;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_rw <= 0; e_mw <= 0; e_rs <= 0; e_rd <= 0;
            e_res <= 0; e_wd <= 0; e_pc4 <= 0;
        end else begin
            e_rw <= RegWriteE; e_mw <= MemWriteE; e_rs <= ResultSrcE; e_rd <= RD_E;
            e_res <= m_res(); e_wd <= m_wd(); e_pc4 <= PCPlus4E;
        end
    end

`ifdef EXEC_PERF_CNT_EN
    logic [31:0] e_exec, e_taken;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_exec <= 0; e_taken <= 0;
        end else begin
            if (RegWriteE || MemWriteE || BranchE) e_exec <= e_exec + 1;
            if (m_taken()) e_taken <= e_taken + 1;
        end
    end
`endif

    // Inputs change at posedge+1, so negedge sees stable values.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_pcsrc",  PCSrcE,     m_taken());
            chk("cmp_target", PCTargetE,  PCE + Imm_Ext_E);
            chk("cmp_rw",     RegWriteM,  e_rw);
            chk("cmp_mw",     MemWriteM,  e_mw);
            chk("cmp_rs",     ResultSrcM, e_rs);
            chk("cmp_rd",     RD_M,       e_rd);
            chk("cmp_res",    ALUResultM, e_res);
            chk("cmp_wd",     WriteDataM, e_wd);
            chk("cmp_pc4",    PCPlus4M,   e_pc4);
`ifdef EXEC_PERF_CNT_EN
            chk("cmp_exec",   exec_cnt,   e_exec);
            chk("cmp_taken",  taken_cnt,  e_taken);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_in();
        RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
        ALUControlE = 0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
        PCE = 0; PCPlus4E = 0; ForwardAE = 0; ForwardBE = 0;
        ALUResultM_fw = 0; ResultW = 0;
    endtask

    task automatic rand_in();
        RegWriteE = 1'($urandom); ALUSrcE = 1'($urandom); MemWriteE = 1'($urandom);
        ResultSrcE = 1'($urandom); BranchE = 1'($urandom);
        ALUControlE = 3'($urandom_range(0, 7));
        RD1_E = $urandom;
        RD2_E = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
        Imm_Ext_E = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) - 32'd32 : $urandom;
        RD_E = 5'($urandom); PCE = $urandom; PCPlus4E = PCE + 4;
        ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
        ALUResultM_fw = $urandom; ResultW = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_case(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        clear_in();
        ALUControlE = op; RD1_E = a; RD2_E = b;
        tick();
        chk(name, ALUResultM, exp);
    endtask

    initial begin
        clear_in();
        #1;
        // 1. reset holds M outputs at zero without any clock edge
        rand_in();
        rst = 1'b0;
        #1;
        chk("rst_rw",  RegWriteM,  0);
        chk("rst_mw",  MemWriteM,  0);
        chk("rst_res", ALUResultM, 0);
        chk("rst_wd",  WriteDataM, 0);
        chk("rst_pc4", PCPlus4M,   0);
        cmp_en = 1'b1;
        tick();
        tick();
        chk("rst_hold_res", ALUResultM, 0);
        rst = 1'b1;
        clear_in();
        ALUControlE = 3'b000; RD1_E = 5; Imm_Ext_E = 7; ALUSrcE = 1;
        tick();
        chk("t1_add", ALUResultM, 12);

        // 2. ALU ops
        alu_case("t2_sub",  3'b001, 32'h8000_0000, 32'h1,  32'h7FFF_FFFF);
        alu_case("t2_slt",  3'b101, 32'h8000_0000, 32'h1,  32'h1);
        alu_case("t2_and",  3'b010, 32'hF0,        32'h3C, 32'h30);
        alu_case("t2_or",   3'b011, 32'hF0,        32'h3C, 32'hFC);
        alu_case("t2_c111", 3'b111, 32'h8000_0000, 32'h1,  32'h0);

        // 3. forwarding
        clear_in();
        ALUControlE = 3'b001; RD1_E = 1; RD2_E = 2; ResultW = 20; ALUResultM_fw = 30;
        ForwardAE = 2'b10; ForwardBE = 2'b01;
        tick();
        chk("t3_fwd_mem_wb", ALUResultM, 10);
        ForwardBE = 2'b11;
        tick();
        chk("t3_fwd_rsvd", ALUResultM, 28);

        // 4. store data comes from forwarded B, not the immediate
        clear_in();
        MemWriteE = 1; ALUSrcE = 1; ForwardBE = 2'b01; ResultW = 32'hDEAD_BEEF; Imm_Ext_E = 4;
        tick();
        chk("t4_wd", WriteDataM, 32'hDEAD_BEEF);
        chk("t4_mw", MemWriteM,  1);

        // 5. branch, same-cycle outputs
        clear_in();
        BranchE = 1; ALUControlE = 3'b001; RD1_E = 9; RD2_E = 9; PCE = 100; Imm_Ext_E = 32'hFFFF_FFF8;
        #1;
        chk("t5_taken",  PCSrcE,    1);
        chk("t5_target", PCTargetE, 92);
        RD2_E = 8;
        #1;
        chk("t5_not_taken", PCSrcE, 0);
        PCE = 32'hFFFF_FFFC; Imm_Ext_E = 8;
        #1;
        chk("t5_wrap", PCTargetE, 4);
        tick();

        // 6. bubble, then mid-cycle async reset
        rand_in();
        RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0; ALUSrcE = 0;
        tick();
        chk("t6_bub_rw", RegWriteM, 0);
        chk("t6_bub_mw", MemWriteM, 0);
        rand_in();
        RegWriteE = 1; MemWriteE = 1; PCPlus4E = 32'h1234;
        tick();
        chk("t6_pre_rw", RegWriteM, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_rw",  RegWriteM,  0);
        chk("t6_async_mw",  MemWriteM,  0);
        chk("t6_async_pc4", PCPlus4M,   0);
        chk("t6_async_rd",  RD_M,       0);
        tick();
        rst = 1'b1;

        // three taken branches after reset
        clear_in();
        BranchE = 1; ALUControlE = 3'b001; RD1_E = 3; RD2_E = 3;
        #1;
        chk("t6_br_taken", PCSrcE, 1);
        tick(); tick(); tick();
`ifdef EXEC_PERF_CNT_EN
        chk("t6_taken_cnt", taken_cnt, 3);
        chk("t6_exec_cnt",  exec_cnt,  3);
`endif

        // random phase with occasional async reset pulses
        for (int i = 0; i < 600; i++) begin
            rand_in();
            rst = ($urandom_range(0, 39) != 0);
            tick();
        end
        rst = 1'b1;
        tick();
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute stage of the 5-stage RV32I pipeline, fed directly by the decode stage's D→E register outputs.
- Selects operands with hazard-unit forwarding, runs the ALU, resolves beq, and computes the branch target.
- Registers results into the E→M pipeline register for the memory stage.
- Branch resolution outputs (PCSrcE, PCTargetE) are combinational and go back to fetch.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- RegWriteE  in  1  register-write control from decode
- ALUSrcE  in  1  ALU source B select: 0 = forwarded RD2, 1 = immediate
- MemWriteE  in  1  store enable
- ResultSrcE  in  1  0 = ALU result, 1 = memory data
- BranchE  in  1  beq instruction
- ALUControlE  in  3  ALU operation
- RD1_E  in  XLEN  rs1 data
- RD2_E  in  XLEN  rs2 data
- Imm_Ext_E  in  XLEN  extended immediate
- RD_E  in  REG_AW  destination register
- PCE  in  XLEN  instruction PC
- PCPlus4E  in  XLEN  PC+4
- ForwardAE  in  2  operand A forward select
- ForwardBE  in  2  operand B forward select
- ALUResultM_fw  in  XLEN  forward path from the M stage
- ResultW  in  XLEN  forward path from the W stage
- PCSrcE  out  1  branch taken (combinational)
- PCTargetE  out  XLEN  PCE + Imm_Ext_E (combinational)
- RegWriteM  out  1  registered
- MemWriteM  out  1  registered
- ResultSrcM  out  1  registered
- RD_M  out  REG_AW  registered
- ALUResultM  out  XLEN  registered
- WriteDataM  out  XLEN  registered forwarded rs2 data
- PCPlus4M  out  XLEN  registered

Behaviour:
- Forward select, applies to A and B: 00 = RD1_E / RD2_E; 01 = ResultW; 10 = ALUResultM_fw; 11 = RD1_E / RD2_E (reserved, treated as 00).
- SrcA = forwarded A.
- SrcB = ALUSrcE ? Imm_Ext_E : forwarded B.
- WriteData = forwarded B, before the ALUSrc mux.
- ALUControl encoding:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 101 SLT: signed compare, result 32'h1 or 32'h0
  - all other codes: result 0
- All arithmetic wraps modulo 2^XLEN; no overflow trap.
- Zero = (ALU result == 0).
- PCSrcE = BranchE & Zero.
- PCTargetE = PCE + Imm_Ext_E, wrapping.
- Both PCSrcE and PCTargetE have zero-cycle latency.
- E→M register updates on every posedge clk. There is no stall or flush input: bubbles arrive from decode as zeroed controls.
- Latency: one cycle from E inputs to M outputs.
- Reset (rst low, asynchronous): all M outputs = 0 immediately, independent of clk.
- Deasserting reset mid-stream: the first posedge after rst goes high captures current E inputs normally.
- Combinational outputs during reset still follow the inputs. Fetch gates them with its own reset.
- A bubble (all controls 0) propagates RegWriteM = 0 and MemWriteM = 0. Data fields carry whatever the ALU computed; these values are don't-care.

Optional Feature:
- Macro EXEC_PERF_CNT_EN.
- Defined: adds outputs exec_cnt (32-bit) and taken_cnt (32-bit).
  - exec_cnt increments on each posedge where RegWriteE | MemWriteE | BranchE.
  - taken_cnt increments on each posedge where PCSrcE.
  - Both wrap at 2^32 and reset to 0 on rst.
- Undefined: neither the ports nor the counter logic exist. Core behaviour is identical in both builds.

Decomposition:
- Shared package pipe_pkg holds:
  - ALUControl constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT.
  - Forward select constants: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
- One sub-module, exec_alu: purely combinational, ports SrcA, SrcB, ALUControl, Result, Zero.
- The forward muxes, branch logic and E→M register stay in execute_cycle.

Test Plan:
1. Reset check: hold rst = 0 with random inputs -> all M outputs = 0, with no clock edge needed. Release rst, apply ADD with RD1 = 5, Imm = 7, ALUSrcE = 1 -> ALUResultM = 12 one cycle later.
2. ALU ops with RD1 = 32'h8000_0000, RD2 = 1:
   - SUB -> 32'h7FFF_FFFF.
   - SLT -> 1.
   - AND with RD1 = F0, RD2 = 3C -> 30.
   - OR of the same -> FC.
   - Code 111 -> 0.
3. Forwarding: RD1 = 1, ResultW = 20, ALUResultM_fw = 30, RD2 = 2, SUB.
   - ForwardAE = 10, ForwardBE = 01 -> ALUResultM = 10.
   - ForwardBE = 11 -> ALUResultM = 28 (30 − RD2).
4. WriteData path: MemWriteE = 1, ALUSrcE = 1, ForwardBE = 01, ResultW = DEAD_BEEF -> WriteDataM = DEAD_BEEF and MemWriteM = 1, next cycle.
5. Branch: BranchE = 1, SUB, RD1 = RD2 = 9, PCE = 100, Imm = −8 -> PCSrcE = 1 and PCTargetE = 92 in the same cycle. With RD2 = 8 -> PCSrcE = 0. PCE = FFFF_FFFC, Imm = 8 -> PCTargetE = 4 (wrap).
6. Bubble and async reset: all controls 0 -> RegWriteM = 0, MemWriteM = 0. Then assert rst between clock edges -> outputs clear immediately. With EXEC_PERF_CNT_EN defined: 3 taken branches -> taken_cnt = 3.
